// File: rtl/dac7311_ctrl.sv
// Write-only SPI controller for a DAC7311-style 12-bit DAC: clamps a signed
// sample to a 12-bit code and shifts a 16-bit frame out on SYNC/SCLK/DIN.
module dac7311_ctrl #(
  parameter int CLK_STEP  = 2,
  parameter int OFFSET    = 2048,
  parameter int SYNC_HIGH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_dac,
  input  logic [12:0] dac_data,
  input  logic [1:0]  dac_pd,
  output logic        dac_busy,
  output logic        dac_finish,
  output logic        dac_sync,
  output logic        dac_sclk,
  output logic        dac_din
);

  typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;

  localparam logic [7:0]  HALF_LAST  = 8'(CLK_STEP - 1);
  localparam logic [7:0]  GUARD_LAST = 8'(SYNC_HIGH - 1);
  localparam logic [13:0] OFS        = 14'(OFFSET);

  state_t      state;
  logic        start;
  logic [15:0] frame;
  logic [7:0]  half_cnt;
  logic [7:0]  guard_cnt;
  logic [4:0]  fall_cnt;
  logic [13:0] sum;
  logic [11:0] code;

  // 14-bit two's-complement sum: bit 13 flags negative, bit 12 flags > 4095
  always_comb begin
    sum = {dac_data[12], dac_data} + OFS;
    if (sum[13])      code = '0;
    else if (sum[12]) code = '1;
    else              code = sum[11:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start      <= 1'b0;
      frame      <= '0;
      half_cnt   <= '0;
      guard_cnt  <= '0;
      fall_cnt   <= '0;
      dac_busy   <= 1'b0;
      dac_finish <= 1'b0;
      dac_sync   <= 1'b1;
      dac_sclk   <= 1'b1;
      dac_din    <= 1'b0;
    end else begin
      dac_finish <= 1'b0;
      case (state)
        IDLE: begin
          // 'start' holds off a second en_dac during the latch-to-SYNC cycle
          if (start) begin
            start    <= 1'b0;
            state    <= SHIFT;
            dac_sync <= 1'b0;
            dac_sclk <= 1'b1;
            dac_din  <= frame[15];
            dac_busy <= 1'b1;
            half_cnt <= '0;
            fall_cnt <= '0;
          end else if (en_dac) begin
            start <= 1'b1;
            frame <= {dac_pd, code, 2'b00};
          end
        end
        SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (dac_sclk) begin
              dac_sclk <= 1'b0;
              fall_cnt <= fall_cnt + 5'd1;
            end else if (fall_cnt == 5'd16) begin
              dac_sclk  <= 1'b1;
              dac_sync  <= 1'b1;
              dac_din   <= 1'b0;
              guard_cnt <= '0;
              state     <= GUARD;
            end else begin
              dac_sclk <= 1'b1;
              frame    <= {frame[14:0], 1'b0};
              dac_din  <= frame[14];
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            state      <= IDLE;
            dac_finish <= 1'b1;
            dac_busy   <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
